// File: rtl/gerenciador_de_ataque_n.sv
// Attack manager for a COLS x ROWS naval-battle grid: edge-detected shots,
// hit/miss/repeat/invalid classification, lives and win/loss tracking.
module gerenciador_de_ataque_n #(
    parameter int unsigned COLS  = 5,
    parameter int unsigned ROWS  = 7,
    parameter int unsigned VIDAS = 3,
    localparam int unsigned CW   = $clog2(COLS),
    localparam int unsigned RW   = $clog2(ROWS),
    localparam int unsigned VW   = $clog2(VIDAS + 1),
    localparam int unsigned N    = COLS * ROWS
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          confirmar,
    input  logic [CW-1:0] coordColuna,
    input  logic [RW-1:0] coordLinha,
    input  logic [N-1:0]  mapa,
    output logic [N-1:0]  matriz,
    output logic [VW-1:0] vida,
    output logic          tem_vida,
    output logic          LED_R,
    output logic          LED_G,
    output logic          LED_B,
    output logic          venceu,
    output logic          repetido,
    output logic          invalido
);

    localparam int unsigned IW = $clog2(N);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        JOGANDO = 2'd1,
        VITORIA = 2'd2,
        DERROTA = 2'd3
    } estado_t;

    estado_t        estado;
    logic           confirmar_q;
    logic [N-1:0]   tiros;

    logic           evento;
    logic           fora;
    logic [IW-1:0]  idx;
    logic [N-1:0]   mask;
    logic           repete;
    logic           acerto;
    logic [N-1:0]   matriz_nxt;
    logic           vence;

    // Decode the targeted cell; an out-of-range target yields an empty mask.
    always_comb begin
        evento     = confirmar & ~confirmar_q;
        fora       = (32'(coordColuna) >= COLS) || (32'(coordLinha) >= ROWS);
        idx        = IW'(coordColuna) * IW'(ROWS) + IW'(coordLinha);
        mask       = fora ? '0 : (N'(1) << idx);
        repete     = |(tiros & mask);
        acerto     = |(mapa & mask);
        matriz_nxt = matriz | mask;
        vence      = (mapa != '0) && ((matriz_nxt & mapa) == mapa);
    end

    assign tem_vida = (vida != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado      <= OCIOSO;
            confirmar_q <= 1'b0;
            tiros       <= '0;
            matriz      <= '0;
            vida        <= VW'(VIDAS);
            LED_R       <= 1'b0;
            LED_G       <= 1'b0;
            LED_B       <= 1'b0;
            venceu      <= 1'b0;
            repetido    <= 1'b0;
            invalido    <= 1'b0;
        end else begin
            confirmar_q <= confirmar;
            repetido    <= 1'b0;
            invalido    <= 1'b0;
            if (!enable) begin
                // Disabling drops any coincident attack and clears the game.
                estado <= OCIOSO;
                tiros  <= '0;
                matriz <= '0;
                vida   <= VW'(VIDAS);
                LED_R  <= 1'b0;
                LED_G  <= 1'b0;
                LED_B  <= 1'b0;
                venceu <= 1'b0;
            end else begin
                case (estado)
                    OCIOSO: estado <= JOGANDO;
                    JOGANDO: begin
                        if (evento) begin
                            if (fora) begin
                                invalido <= 1'b1;
                            end else if (repete) begin
                                repetido <= 1'b1;
                            end else if (acerto) begin
                                matriz <= matriz_nxt;
                                tiros  <= tiros | mask;
                                LED_G  <= 1'b1;
                                LED_R  <= 1'b0;
                                if (vence) begin
                                    estado <= VITORIA;
                                    venceu <= 1'b1;
                                end
                            end else begin
                                tiros <= tiros | mask;
                                LED_R <= 1'b1;
                                LED_G <= 1'b0;
                                if (vida != '0) vida <= vida - VW'(1);
                                if (vida <= VW'(1)) begin
                                    estado <= DERROTA;
                                    LED_B  <= 1'b1;
                                end
                            end
                        end
                    end
                    default: estado <= estado;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gerenciador_de_ataque_n.sv
// Directed bench for gerenciador_de_ataque_n with the default 5x7 grid and 3 lives.
module tb_gerenciador_de_ataque_n;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        confirmar;
    logic [2:0]  coordColuna;
    logic [2:0]  coordLinha;
    logic [34:0] mapa;
    logic [34:0] matriz;
    logic [1:0]  vida;
    logic        tem_vida, LED_R, LED_G, LED_B, venceu, repetido, invalido;

    int passed = 0;
    int total  = 0;

    localparam logic [34:0] MAPA_STD = 35'h400000011;

    gerenciador_de_ataque_n dut (
        .clock(clock), .reset(reset), .enable(enable), .confirmar(confirmar),
        .coordColuna(coordColuna), .coordLinha(coordLinha), .mapa(mapa),
        .matriz(matriz), .vida(vida), .tem_vida(tem_vida), .LED_R(LED_R),
        .LED_G(LED_G), .LED_B(LED_B), .venceu(venceu), .repetido(repetido),
        .invalido(invalido)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Clear via enable, then re-enable; returns #1 after the edge entering JOGANDO.
    task automatic restart();
        @(negedge clock);
        enable = 1'b0; confirmar = 1'b0;
        @(posedge clock);
        @(negedge clock);
        enable = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic press(input logic [2:0] c, input logic [2:0] r);
        @(negedge clock);
        coordColuna = c; coordLinha = r; confirmar = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic release_btn();
        @(negedge clock);
        confirmar = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; confirmar = 1'b0;
        coordColuna = '0; coordLinha = '0; mapa = MAPA_STD;
        #12;
        total++; if (matriz !== 35'h0) $display("FAIL reset_matriz: got %0h expected 0", matriz); else passed++;
        total++; if (vida !== 2'd3) $display("FAIL reset_vida: got %0d expected 3", vida); else passed++;
        total++; if ({tem_vida, LED_R, LED_G, LED_B, venceu, repetido, invalido} !== 7'b1000000)
            $display("FAIL reset_flags: got %b expected 1000000",
                     {tem_vida, LED_R, LED_G, LED_B, venceu, repetido, invalido});
        else passed++;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_hit();
        restart();
        press(3'd0, 3'd0);
        total++; if (matriz !== 35'h1) $display("FAIL hit_matriz: got %0h expected 1", matriz); else passed++;
        total++; if ({LED_G, LED_R} !== 2'b10) $display("FAIL hit_leds: got %b expected 10", {LED_G, LED_R}); else passed++;
        total++; if (vida !== 2'd3) $display("FAIL hit_vida: got %0d expected 3", vida); else passed++;
        release_btn();
    endtask

    task automatic test_miss_repeat();
        restart();
        press(3'd1, 3'd1);
        total++; if (vida !== 2'd2) $display("FAIL miss_vida: got %0d expected 2", vida); else passed++;
        total++; if ({LED_R, LED_G, repetido} !== 3'b100) $display("FAIL miss_flags: got %b expected 100", {LED_R, LED_G, repetido}); else passed++;
        release_btn();
        press(3'd1, 3'd1);
        total++; if (repetido !== 1'b1) $display("FAIL rep_pulse: got %b expected 1", repetido); else passed++;
        total++; if (vida !== 2'd2) $display("FAIL rep_vida: got %0d expected 2", vida); else passed++;
        total++; if (matriz !== 35'h0) $display("FAIL rep_matriz: got %0h expected 0", matriz); else passed++;
        release_btn();
        total++; if (repetido !== 1'b0) $display("FAIL rep_one_cycle: got %b expected 0", repetido); else passed++;
    endtask

    task automatic test_invalid();
        restart();
        press(3'd5, 3'd0);
        total++; if (invalido !== 1'b1) $display("FAIL inv_col: got %b expected 1", invalido); else passed++;
        release_btn();
        total++; if (invalido !== 1'b0) $display("FAIL inv_one_cycle: got %b expected 0", invalido); else passed++;
        press(3'd0, 3'd7);
        total++; if (invalido !== 1'b1) $display("FAIL inv_row: got %b expected 1", invalido); else passed++;
        total++; if ({matriz, vida} !== {35'h0, 2'd3}) $display("FAIL inv_state: got %0h/%0d expected 0/3", matriz, vida); else passed++;
        release_btn();
    endtask

    task automatic test_win();
        restart();
        press(3'd0, 3'd0); release_btn();
        press(3'd0, 3'd4);
        total++; if (venceu !== 1'b0) $display("FAIL win_early: got %b expected 0", venceu); else passed++;
        release_btn();
        press(3'd4, 3'd6);
        total++; if (venceu !== 1'b1) $display("FAIL win_flag: got %b expected 1", venceu); else passed++;
        total++; if (matriz !== MAPA_STD) $display("FAIL win_matriz: got %0h expected %0h", matriz, MAPA_STD); else passed++;
        release_btn();
        press(3'd1, 3'd1);
        total++; if ({vida, LED_R, LED_G, venceu} !== {2'd3, 3'b011}) $display("FAIL win_ignore: got %b expected 11011", {vida, LED_R, LED_G, venceu}); else passed++;
        release_btn();
    endtask

    task automatic test_loss();
        restart();
        press(3'd1, 3'd1); release_btn();
        press(3'd2, 3'd2); release_btn();
        total++; if (LED_B !== 1'b0) $display("FAIL loss_early: got %b expected 0", LED_B); else passed++;
        press(3'd3, 3'd3);
        total++; if ({vida, tem_vida, LED_B, venceu} !== {2'd0, 3'b010}) $display("FAIL loss_state: got %b expected 00010", {vida, tem_vida, LED_B, venceu}); else passed++;
        release_btn();
        press(3'd0, 3'd0);
        total++; if ({matriz, vida} !== {35'h0, 2'd0}) $display("FAIL loss_ignore: got %0h/%0d expected 0/0", matriz, vida); else passed++;
        release_btn();
        @(negedge clock); enable = 1'b0;
        @(posedge clock); #1;
        total++; if ({vida, LED_B, LED_R} !== {2'd3, 2'b00}) $display("FAIL loss_clear: got %b expected 1100", {vida, LED_B, LED_R}); else passed++;
    endtask

    task automatic test_held_button();
        int extra = 0;
        restart();
        press(3'd1, 3'd1);
        for (int i = 0; i < 9; i++) begin
            @(posedge clock); #1;
            if (repetido === 1'b1) extra++;
        end
        total++; if (vida !== 2'd2) $display("FAIL held_vida: got %0d expected 2", vida); else passed++;
        total++; if (extra !== 0) $display("FAIL held_pulses: got %0d expected 0", extra); else passed++;
        release_btn();
    endtask

    task automatic test_reset_mid_game();
        restart();
        press(3'd0, 3'd0);
        release_btn();
        #2 reset = 1'b0;
        #1;
        total++; if ({matriz, vida, LED_G} !== {35'h0, 2'd3, 1'b0}) $display("FAIL async_reset: got %0h/%0d/%b expected 0/3/0", matriz, vida, LED_G); else passed++;
        @(negedge clock);
        reset = 1'b1; coordColuna = 3'd0; coordLinha = 3'd0; confirmar = 1'b1;
        @(posedge clock); #1;
        total++; if (matriz !== 35'h0) $display("FAIL ocioso_ignore: got %0h expected 0", matriz); else passed++;
        release_btn();
        press(3'd0, 3'd0);
        total++; if (matriz !== 35'h1) $display("FAIL after_reset_hit: got %0h expected 1", matriz); else passed++;
        release_btn();
    endtask

    task automatic test_enable_same_edge();
        restart();
        @(negedge clock);
        enable = 1'b0; coordColuna = 3'd0; coordLinha = 3'd0; confirmar = 1'b1;
        @(posedge clock); #1;
        total++; if ({matriz, LED_G} !== {35'h0, 1'b0}) $display("FAIL enable_drop: got %0h/%b expected 0/0", matriz, LED_G); else passed++;
        @(negedge clock); confirmar = 1'b0; enable = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_empty_map();
        @(negedge clock); enable = 1'b0; mapa = 35'h0;
        restart();
        press(3'd0, 3'd0);
        total++; if ({vida, venceu, LED_R} !== {2'd2, 2'b01}) $display("FAIL empty_map: got %b expected 1001", {vida, venceu, LED_R}); else passed++;
        release_btn();
        @(negedge clock); enable = 1'b0; mapa = MAPA_STD;
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss_repeat();
        test_invalid();
        test_win();
        test_loss();
        test_held_button();
        test_reset_mid_game();
        test_enable_same_edge();
        test_empty_map();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
